// File: rtl/sntc_ldpc_pkg.sv
// rtl/sntc_ldpc_pkg.sv - shared sizes, launch-state type and counter helper for the LDPC input loader
package sntc_ldpc_pkg;

  localparam int NN_DEF    = 'h000d0;
  localparam int BEAT_DEF  = 8;
  localparam int NBEAT_DEF = NN_DEF / BEAT_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } launch_st_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sntc_ldpc_frame_assembler.sv
// rtl/sntc_ldpc_frame_assembler.sv - beat counting, frame length check and discard of over-long frames
module sntc_ldpc_frame_assembler
  import sntc_ldpc_pkg::*;
#(
  parameter int  NBEAT = NBEAT_DEF,
  localparam int IW    = $clog2(NBEAT)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          s_valid,
  input  logic          s_last,
  input  logic          bank_full,
  output logic          s_ready,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic          frame_done,
  output logic          frame_bad
);

  logic [IW-1:0] cnt_q, cnt_d;
  logic          discard_q, discard_d;
  logic          accept;
  logic          at_end;

  // While discarding, beats are swallowed even if the target bank is still occupied.
  assign s_ready = !bank_full || discard_q;
  assign accept  = s_valid && s_ready;
  assign at_end  = (cnt_q == IW'(NBEAT - 1));
  assign wr_en   = accept && !discard_q;
  assign wr_idx  = cnt_q;

  always_comb begin
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (accept) begin
      if (discard_q) begin
        if (s_last) begin
          discard_d = 1'b0;
          cnt_d     = '0;
        end
      end else if (s_last) begin
        cnt_d = '0;
        if (at_end) begin
          frame_done = 1'b1;
        end else begin
          frame_bad = 1'b1;
        end
      end else if (at_end) begin
        cnt_d     = '0;
        discard_d = 1'b1;
        frame_bad = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: rtl/sntc_ldpc_input_loader.sv
// rtl/sntc_ldpc_input_loader.sv - double-banked channel-input loader with decoder launch FSM
module sntc_ldpc_input_loader
  import sntc_ldpc_pkg::*;
#(
  parameter int NN   = NN_DEF,
  parameter int BEAT = BEAT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2*BEAT-1:0] s_sym,
  input  logic              s_last,
  output logic [NN-1:0]     q0_0,
  output logic [NN-1:0]     q0_1,
  output logic              start,
  input  logic              dec_done,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int NBEAT = NN / BEAT;
  localparam int IW    = $clog2(NBEAT);
  localparam int BW    = $clog2(NN);

  logic [NN-1:0]   q00_bank_q [2];
  logic [NN-1:0]   q01_bank_q [2];
  logic [1:0]      full_q, full_d;
  logic            wr_ptr_q, rd_ptr_q;
  launch_st_e      st_q;
  logic            start_q, frame_err_q;
  logic [15:0]     frame_cnt_q, drop_cnt_q;

  logic            wr_en, frame_done, frame_bad, release_bank;
  logic [IW-1:0]   wr_idx;
  logic [BW-1:0]   wr_base;
  logic [BEAT-1:0] sym0, sym1;

  sntc_ldpc_frame_assembler #(
    .NBEAT (NBEAT)
  ) u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .bank_full  (full_q[wr_ptr_q]),
    .s_ready    (s_ready),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .frame_done (frame_done),
    .frame_bad  (frame_bad)
  );

  always_comb begin
    sym0 = '0;
    sym1 = '0;
    for (int k = 0; k < BEAT; k++) begin
      sym0[k] = s_sym[2*k];
      sym1[k] = s_sym[2*k+1];
    end
  end

  assign wr_base      = BW'(wr_idx) * BW'(BEAT);
  assign release_bank = (st_q == BUSY) && dec_done;

  // Fill and release never target the same bank in one cycle, so both edits can apply.
  always_comb begin
    full_d = full_q;
    if (frame_done) begin
      full_d[wr_ptr_q] = 1'b1;
    end
    if (release_bank) begin
      full_d[rd_ptr_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      for (int i = 0; i < 2; i++) begin
        q00_bank_q[i] <= '0;
        q01_bank_q[i] <= '0;
      end
      full_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      st_q        <= IDLE;
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      start_q     <= 1'b0;
      frame_err_q <= frame_bad;
      full_q      <= full_d;
      if (frame_bad) begin
        drop_cnt_q <= sat_inc16(drop_cnt_q);
      end
      if (wr_en) begin
        q00_bank_q[wr_ptr_q][wr_base +: BEAT] <= sym0;
        q01_bank_q[wr_ptr_q][wr_base +: BEAT] <= sym1;
      end
      if (frame_done) begin
        wr_ptr_q <= !wr_ptr_q;
      end
      case (st_q)
        IDLE: begin
          if (full_q[rd_ptr_q]) begin
            st_q    <= LAUNCH;
            start_q <= 1'b1;
          end
        end
        LAUNCH: begin
          frame_cnt_q <= sat_inc16(frame_cnt_q);
          st_q        <= BUSY;
        end
        BUSY: begin
          if (dec_done) begin
            st_q     <= IDLE;
            rd_ptr_q <= !rd_ptr_q;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign q0_0      = q00_bank_q[rd_ptr_q];
  assign q0_1      = q01_bank_q[rd_ptr_q];
  assign start     = start_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/sntc_ldpc_input_loader.md
SNTC_LDPC_INPUT_LOADER -- requirements
Module: sntc_ldpc_input_loader

Interface
REQ-001 SHALL have parameter NN, default 'h000d0, codeword length in bits.
REQ-002 SHALL have parameter BEAT, default 8, symbols per input beat; NN SHALL be a multiple of BEAT, giving NBEAT = NN/BEAT (26 at default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port clr, input, 1 bit: synchronous soft clear, same effect as reset.
REQ-006 SHALL have port s_valid, input, 1 bit: an input beat is present.
REQ-007 SHALL have port s_ready, output, 1 bit: the loader accepts the beat.
REQ-008 SHALL have port s_sym, input, 2*BEAT bits: symbol k uses bits [2k+1:2k] as {q0_1 bit, q0_0 bit}.
REQ-009 SHALL have port s_last, input, 1 bit: marks the final beat of a frame.
REQ-010 SHALL have ports q0_0 and q0_1, outputs, NN bits each: decoder channel inputs, held stable from start until dec_done.
REQ-011 SHALL have port start, output, 1 bit: single-cycle decoder launch pulse.
REQ-012 SHALL have port dec_done, input, 1 bit: decoder valid/completion pulse.
REQ-013 SHALL have port frame_err, output, 1 bit: single-cycle pulse when a malformed frame is detected.
REQ-014 SHALL have ports frame_cnt and drop_cnt, outputs, 16 bits each: count of launched frames and of dropped frames.

Function
REQ-015 SHALL hold two frame banks (bank 0 and bank 1), each NN bits of q0_0 plus NN bits of q0_1, with per-bank full flags, a write pointer wr_ptr and a read pointer rd_ptr.
REQ-016 SHALL accept a beat when s_valid && s_ready; beat index b writes symbol k to bit position b*BEAT+k of bank wr_ptr.
REQ-017 SHALL drive s_ready = !full[wr_ptr] || discarding.
REQ-018 SHALL use a beat counter that counts 0..NBEAT-1 and returns to 0 on frame completion, error, or clr.
REQ-019 On an accepted beat with s_last=1 and index NBEAT-1, SHALL set full[wr_ptr], toggle wr_ptr, and clear the beat counter.
REQ-020 On s_last=1 at an index below NBEAT-1 (short frame), SHALL pulse frame_err, increment drop_cnt, clear the beat counter, and leave the bank not full.
REQ-021 On s_last=0 at index NBEAT-1 (long frame), SHALL pulse frame_err, increment drop_cnt, and enter DISCARD.
REQ-022 In DISCARD, SHALL accept and drop beats until a beat with s_last=1, then return to FILL with the beat counter at 0.
REQ-023 SHALL run a launch FSM with states IDLE, LAUNCH and BUSY.
REQ-024 IDLE -> LAUNCH when full[rd_ptr]=1.
REQ-025 LAUNCH: SHALL assert start for exactly 1 cycle, increment frame_cnt, and go to BUSY.
REQ-026 BUSY -> IDLE on dec_done; SHALL clear full[rd_ptr] and toggle rd_ptr in the same cycle.
REQ-027 SHALL drive q0_0/q0_1 combinationally from bank rd_ptr, so they are valid in the start cycle and stable throughout BUSY.
REQ-028 When a bank completes and dec_done occurs in the same cycle, SHALL update both flags independently; the next start follows no sooner than 1 cycle after IDLE is re-entered (start-to-start minimum 3 cycles).
REQ-029 SHALL ignore dec_done outside BUSY.
REQ-030 SHALL saturate frame_cnt and drop_cnt at 'hFFFF.
REQ-031 Latency: the last accepted beat at edge t gives start=1 in cycle t+2 when the FSM is IDLE.

Reset
REQ-032 While rstn=0 or clr=1 at a clock edge, SHALL reset: banks, full flags, pointers, beat counter and counters to 0; FSM to IDLE; discard flag to 0; start and frame_err to 0; s_ready to 1.
REQ-033 A reset or clr during BUSY SHALL abandon the frame with no start or frame_err pulse.

Structure
REQ-034 SHALL place the NN/BEAT defaults, NBEAT, and the launch-state enum (IDLE/LAUNCH/BUSY) in shared package sntc_ldpc_pkg.
REQ-035 SHALL implement the beat assembly, length check and discard logic in one sub-module, sntc_ldpc_frame_assembler; bank storage and the launch FSM stay in the top level.

Verification
REQ-036 Bench SHALL cover: 26 beats, s_last on beat 25, symbols all 2'b01 -> start 2 cycles later; q0_0 = all ones, q0_1 = 0; frame_cnt = 1.
REQ-037 Bench SHALL cover: 3 back-to-back frames with dec_done withheld -> 2 banks fill, s_ready = 0 on the 3rd frame's first beat; one dec_done -> s_ready = 1 next cycle, second start follows.
REQ-038 Bench SHALL cover: s_last on beat 10 -> frame_err pulse, drop_cnt = 1, no start; the next good frame launches normally.
REQ-039 Bench SHALL cover: no s_last on beat 25, s_last on beat 30 -> frame_err at beat 25, beats 26..30 dropped, next frame correct.
REQ-040 Bench SHALL cover: bank completion coinciding with dec_done -> rd_ptr toggles, start for the other bank 2 cycles later, no frame lost.
REQ-041 Bench SHALL cover: clr asserted mid-BUSY -> all outputs reset next cycle, a late dec_done is ignored, the next frame gives frame_cnt = 1.
